irq_timer_bank: RTL

Multi-channel periodic interrupt generator that drives the MCU external interrupt request (ei_req) in board tops. It generalises the fixed 8 kHz divider-plus-latch to N channels. Each channel adds a runtime-programmable period, periodic or one-shot mode, a level clear, and an overrun flag. A shared prescaler, an OR-combined request and a lowest-index pending channel id complete the block.

---
 rtl/yrv_board_pkg.sv | 18 +
 rtl/irq_timer_channel.sv | 58 +++++
 rtl/irq_timer_bank.sv | 68 ++++++
 3 files changed

// File: rtl/yrv_board_pkg.sv
// rtl/yrv_board_pkg.sv - shared board constants, channel control type and period helper
package yrv_board_pkg;

    localparam int CLK_FREQUENCY = 50_000_000;
    localparam int CTRL_PERIOD_W = 16;

    typedef struct packed {
        logic                     en;
        logic                     oneshot;
        logic [CTRL_PERIOD_W-1:0] period;
    } ch_ctrl_t;

    // Terminal count giving an interrupt rate of hz with the given prescaler ratio
    function automatic int period_for_hz(input int hz, input int presc);
        return CLK_FREQUENCY / (hz * presc) - 1;
    endfunction

endpackage

// File: rtl/irq_timer_channel.sv
// rtl/irq_timer_channel.sv - one timer channel: counter, one-shot done flag, req/ovf latches
module irq_timer_channel
    import yrv_board_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             en,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] period,
    input  logic             clr,
    output logic             req,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             req_q, req_d;
    logic             ovf_q, ovf_d;
    logic             fire;

    // >= rather than == so a period lowered below the running count fires at once
    assign fire = en & tick & ~done_q & (cnt_q >= period);

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (!en) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (tick && !done_q) begin
            cnt_d  = fire ? '0 : cnt_q + CNT_W'(1);
            done_d = fire & oneshot;
        end
        req_d = ~clr & (fire | req_q);
        ovf_d = ~clr & (ovf_q | (fire & req_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            req_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            req_q  <= req_d;
            ovf_q  <= ovf_d;
        end
    end

    assign req = req_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/irq_timer_bank.sv
// rtl/irq_timer_bank.sv - N-channel periodic interrupt generator with shared prescaler
module irq_timer_bank
    import yrv_board_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16,
    parameter int PRESC = 1,
    parameter int ID_W  = (N_CH > 1 ? $clog2(N_CH) : 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       ch_oneshot,
    input  logic [N_CH*CNT_W-1:0] ch_period,
    input  logic [N_CH-1:0]       ch_clr,
    output logic [N_CH-1:0]       ch_req,
    output logic [N_CH-1:0]       ch_ovf,
    output logic                  ei_req,
    output logic [ID_W-1:0]       ei_id
);

    logic tick;

    generate
        if (PRESC == 1) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            localparam int PW = $clog2(PRESC);
            logic [PW-1:0] presc_q, presc_d;

            // Free-running, deliberately not gated by any channel enable
            assign tick    = (presc_q == PW'(PRESC - 1));
            assign presc_d = tick ? '0 : presc_q + PW'(1);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) presc_q <= '0;
                else          presc_q <= presc_d;
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            irq_timer_channel #(.CNT_W(CNT_W)) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .tick    (tick),
                .en      (ch_en[i]),
                .oneshot (ch_oneshot[i]),
                .period  (ch_period[i*CNT_W +: CNT_W]),
                .clr     (ch_clr[i]),
                .req     (ch_req[i]),
                .ovf     (ch_ovf[i])
            );
        end
    endgenerate

    assign ei_req = |ch_req;

    // Scan high to low so the lowest pending index is the one left standing
    always_comb begin
        ei_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) ei_id = ID_W'(i);
        end
    end

endmodule
